// File: rtl/bus_endpoint_if.sv
// bus_endpoint_if: bundles every host-side and arbiter-side signal of one
// bus_endpoint device port.
//   slave  : the endpoint itself. It receives wr_en/wr_data, pop, push/D_push
//            and rd_en, and drives FIFO status, heads, counters and err.
//   master : the host and arbiter pair that drives the endpoint.
// Handshake semantics: every request input (wr_en, pop, push, rd_en) is a
// single-cycle strobe sampled on posedge clk. It is honoured only when the
// matching status allows it at that edge: wr_en needs !tx_full, pop needs
// pndng, rd_en needs rx_valid, and an accepted push needs room in the RX FIFO.
// A strobe that is not honoured is dropped, never retried or held.
interface bus_endpoint_if #(
  parameter int pckg_sz = 16,
  parameter int depth   = 8
);
  localparam int CW = $clog2(depth + 1);

  logic               wr_en;
  logic [pckg_sz-1:0] wr_data;
  logic               tx_full;
  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [pckg_sz-1:0] D_push;
  logic               rx_valid;
  logic [pckg_sz-1:0] rd_data;
  logic               rd_en;
  logic [CW-1:0]      tx_count;
  logic [CW-1:0]      rx_count;
  logic [7:0]         ovf_cnt;
  logic [7:0]         misroute_cnt;
  logic               err;

  modport slave (
    input  wr_en, wr_data, pop, push, D_push, rd_en,
    output tx_full, pndng, D_pop, rx_valid, rd_data,
           tx_count, rx_count, ovf_cnt, misroute_cnt, err
  );

  modport master (
    output wr_en, wr_data, pop, push, D_push, rd_en,
    input  tx_full, pndng, D_pop, rx_valid, rd_data,
           tx_count, rx_count, ovf_cnt, misroute_cnt, err
  );
endinterface

// File: rtl/bus_endpoint.sv
// bus_endpoint: device-side endpoint of the arbiter FIFO protocol.
// The TX show-ahead FIFO is filled by the host (wr_en/wr_data) and drained by
// the arbiter (pndng/D_pop/pop). The RX show-ahead FIFO is filled by the
// arbiter (push/D_push) with packets whose destination byte matches id or
// broadcast, and it is drained by the host (rx_valid/rd_data/rd_en).
// Ports:
//   clk   : clock. All state changes on posedge.
//   reset : synchronous, active-high. It overrides every input in its cycle.
//   bus   : bus_endpoint_if.slave. It carries the FIFO handshakes, the
//           occupancies, the drop counters and the sticky err flag.
module bus_endpoint #(
  parameter int         pckg_sz   = 16,
  parameter int         depth     = 8,
  parameter logic [7:0] id        = 8'h00,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  bus_endpoint_if.slave     bus
);
  localparam int            CW   = $clog2(depth + 1);
  localparam int            AW   = $clog2(depth);
  localparam logic [CW-1:0] FULL = CW'(depth);

  logic [pckg_sz-1:0] tx_mem_q [depth];
  logic [pckg_sz-1:0] rx_mem_q [depth];

  logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [7:0]    ovf_cnt_q, ovf_cnt_d, mis_cnt_q, mis_cnt_d;
  logic          err_q, err_d;

  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic       tx_wr, tx_rd, rx_wr, rx_rd;
  logic       rx_hit, rx_ovf, rx_mis;
  logic [7:0] dest;

  // All status is derived from the pre-edge counts. A pop or read in the same
  // cycle therefore never makes room for a write or push at a full FIFO.
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == FULL);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL);

  assign dest   = bus.D_push[pckg_sz-1 -: 8];
  assign rx_hit = bus.push && ((dest == id) || (dest == broadcast));
  assign rx_wr  = rx_hit && !rx_full;
  assign rx_ovf = rx_hit && rx_full;
  assign rx_mis = bus.push && !rx_hit;
  assign rx_rd  = bus.rd_en && !rx_empty;

  assign tx_wr = bus.wr_en && !tx_full;
  assign tx_rd = bus.pop && !tx_empty;

  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q + AW'(tx_wr);
    tx_rd_ptr_d = tx_rd_ptr_q + AW'(tx_rd);
    rx_wr_ptr_d = rx_wr_ptr_q + AW'(rx_wr);
    rx_rd_ptr_d = rx_rd_ptr_q + AW'(rx_rd);
    tx_cnt_d    = tx_cnt_q + CW'(tx_wr) - CW'(tx_rd);
    rx_cnt_d    = rx_cnt_q + CW'(rx_wr) - CW'(rx_rd);
    ovf_cnt_d   = ovf_cnt_q;
    mis_cnt_d   = mis_cnt_q;
    if (rx_ovf && (ovf_cnt_q != 8'hFF)) ovf_cnt_d = ovf_cnt_q + 8'd1;
    if (rx_mis && (mis_cnt_q != 8'hFF)) mis_cnt_d = mis_cnt_q + 8'd1;
    err_d = err_q | (bus.wr_en & tx_full) | (bus.pop & tx_empty)
                  | (bus.rd_en & rx_empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      ovf_cnt_q   <= '0;
      mis_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      ovf_cnt_q   <= ovf_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
      err_q       <= err_d;
    end
  end

  // Storage is not reset. The heads are masked to 0 while the FIFO is empty,
  // so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (!reset && tx_wr) tx_mem_q[tx_wr_ptr_q] <= bus.wr_data;
    if (!reset && rx_wr) rx_mem_q[rx_wr_ptr_q] <= bus.D_push;
  end

  assign bus.tx_full      = tx_full;
  assign bus.pndng        = !tx_empty;
  assign bus.D_pop        = tx_empty ? '0 : tx_mem_q[tx_rd_ptr_q];
  assign bus.rx_valid     = !rx_empty;
  assign bus.rd_data      = rx_empty ? '0 : rx_mem_q[rx_rd_ptr_q];
  assign bus.tx_count     = tx_cnt_q;
  assign bus.rx_count     = rx_cnt_q;
  assign bus.ovf_cnt      = ovf_cnt_q;
  assign bus.misroute_cnt = mis_cnt_q;
  assign bus.err          = err_q;
endmodule

// File: tb/tb_bus_endpoint.sv
// tb_bus_endpoint: self-checking bench for bus_endpoint (pckg_sz=16, depth=8,
// id=8'h02, broadcast=8'hFF). Inputs are driven 1 time unit after posedge.
// Outputs are sampled at that same point, which is well away from the edge.
module tb_bus_endpoint;
  localparam int W = 16;
  localparam int D = 8;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  logic [W-1:0] tx_exp_q[$];
  logic [W-1:0] rx_exp_q[$];
  logic [W-1:0] exp_v;
  logic [7:0]   exp_mis;
  logic [7:0]   exp_ovf;
  logic         err_before;

  bus_endpoint_if #(.pckg_sz(W), .depth(D)) bus ();

  bus_endpoint #(.pckg_sz(W), .depth(D), .id(8'h02), .broadcast(8'hFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.pop = 1'b0;
    bus.push = 1'b0; bus.D_push = '0; bus.rd_en = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tx_exp_q.delete();
    rx_exp_q.delete();
    exp_mis = 8'd0;
    exp_ovf = 8'd0;
  endtask

  // ---------------- driver helpers (model bookkeeping) ----------------
  // This applies the arbiter push to the RX model using the pre-edge occupancy.
  task automatic model_push(input logic [W-1:0] pkt);
    if (pkt[W-1 -: 8] == 8'h02 || pkt[W-1 -: 8] == 8'hFF) begin
      if (rx_exp_q.size() < D) rx_exp_q.push_back(pkt);
      else if (exp_ovf != 8'hFF) exp_ovf++;
    end else if (exp_mis != 8'hFF) exp_mis++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    total_cnt++; if (bus.tx_count !== 4'd0) $display("FAIL reset_tx_count: got %0d expected 0", bus.tx_count); else pass_cnt++;
    total_cnt++; if (bus.rx_count !== 4'd0) $display("FAIL reset_rx_count: got %0d expected 0", bus.rx_count); else pass_cnt++;
    total_cnt++; if ({bus.pndng, bus.rx_valid, bus.tx_full, bus.err} !== 4'b0) $display("FAIL reset_flags: got %b expected 0000", {bus.pndng, bus.rx_valid, bus.tx_full, bus.err}); else pass_cnt++;
    total_cnt++; if ({bus.D_pop, bus.rd_data} !== '0) $display("FAIL reset_heads: got %h/%h expected 0/0", bus.D_pop, bus.rd_data); else pass_cnt++;
    total_cnt++; if ({bus.ovf_cnt, bus.misroute_cnt} !== 16'd0) $display("FAIL reset_cnts: got %0d/%0d expected 0/0", bus.ovf_cnt, bus.misroute_cnt); else pass_cnt++;
  endtask

  task automatic test_tx_basic();
    do_reset();
    bus.wr_en = 1'b1; bus.wr_data = 16'h0012; tx_exp_q.push_back(16'h0012);
    tick();
    total_cnt++; if (bus.pndng !== 1'b1) $display("FAIL tx_basic_pndng: got %b expected 1", bus.pndng); else pass_cnt++;
    total_cnt++; if (bus.D_pop !== tx_exp_q[0]) $display("FAIL tx_basic_head1: got %h expected %h", bus.D_pop, tx_exp_q[0]); else pass_cnt++;
    bus.wr_data = 16'h0034; tx_exp_q.push_back(16'h0034);
    tick();
    bus.wr_en = 1'b0;
    bus.pop = 1'b1; void'(tx_exp_q.pop_front());
    tick();
    bus.pop = 1'b0;
    total_cnt++; if (bus.D_pop !== tx_exp_q[0]) $display("FAIL tx_basic_head2: got %h expected %h", bus.D_pop, tx_exp_q[0]); else pass_cnt++;
    total_cnt++; if (bus.tx_count !== 4'd1) $display("FAIL tx_basic_count: got %0d expected 1", bus.tx_count); else pass_cnt++;
    bus.pop = 1'b1; void'(tx_exp_q.pop_front());
    tick();
    bus.pop = 1'b0;
    total_cnt++; if ({bus.pndng, bus.err} !== 2'b00) $display("FAIL tx_basic_drained: got pndng/err %b expected 00", {bus.pndng, bus.err}); else pass_cnt++;
    total_cnt++; if (bus.D_pop !== 16'h0000) $display("FAIL tx_basic_empty_head: got %h expected 0000", bus.D_pop); else pass_cnt++;
  endtask

  task automatic test_tx_full();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = W'($urandom_range(0, 16'hFFFF));
      if (tx_exp_q.size() < D) tx_exp_q.push_back(bus.wr_data);
      tick();
      if (i == 7) begin
        total_cnt++; if (bus.tx_full !== 1'b1) $display("FAIL tx_full_flag: got %b expected 1", bus.tx_full); else pass_cnt++;
        total_cnt++; if (bus.err !== 1'b0) $display("FAIL tx_full_err_early: got %b expected 0", bus.err); else pass_cnt++;
      end
    end
    bus.wr_en = 1'b0;
    total_cnt++; if (bus.err !== 1'b1) $display("FAIL tx_full_err: got %b expected 1", bus.err); else pass_cnt++;
    total_cnt++; if (bus.tx_count !== 4'd8) $display("FAIL tx_full_count: got %0d expected 8", bus.tx_count); else pass_cnt++;
    while (tx_exp_q.size() > 0) begin
      exp_v = tx_exp_q.pop_front();
      total_cnt++; if (bus.D_pop !== exp_v) $display("FAIL tx_full_order: got %h expected %h", bus.D_pop, exp_v); else pass_cnt++;
      bus.pop = 1'b1;
      tick();
    end
    tick();
    bus.pop = 1'b0;
    total_cnt++; if ({bus.err, bus.tx_count} !== 5'b1_0000) $display("FAIL tx_full_extra_pop: got err/count %b/%0d expected 1/0", bus.err, bus.tx_count); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.wr_en = 1'b1; bus.wr_data = 16'h1111; tx_exp_q.push_back(16'h1111);
    tick();
    bus.pop = 1'b1; bus.wr_data = 16'h2222;
    void'(tx_exp_q.pop_front()); tx_exp_q.push_back(16'h2222);
    tick();
    total_cnt++; if (bus.tx_count !== 4'd1) $display("FAIL b2b_count: got %0d expected 1", bus.tx_count); else pass_cnt++;
    total_cnt++; if (bus.D_pop !== tx_exp_q[0]) $display("FAIL b2b_head: got %h expected %h", bus.D_pop, tx_exp_q[0]); else pass_cnt++;
    bus.wr_en = 1'b0; void'(tx_exp_q.pop_front());
    tick();
    bus.wr_en = 1'b1; bus.wr_data = 16'h3333; tx_exp_q.push_back(16'h3333);
    tick();
    bus.wr_en = 1'b0; bus.pop = 1'b0;
    total_cnt++; if ({bus.err, bus.tx_count} !== 5'b1_0001) $display("FAIL b2b_empty_wr_pop: got err/count %b/%0d expected 1/1", bus.err, bus.tx_count); else pass_cnt++;
    total_cnt++; if (bus.D_pop !== tx_exp_q[0]) $display("FAIL b2b_empty_head: got %h expected %h", bus.D_pop, tx_exp_q[0]); else pass_cnt++;
  endtask

  task automatic test_rx_filter();
    logic [W-1:0] pkts [3];
    do_reset();
    pkts[0] = 16'h0255; pkts[1] = 16'hFF66; pkts[2] = 16'h0377;
    for (int i = 0; i < 3; i++) begin
      bus.push = 1'b1; bus.D_push = pkts[i]; model_push(pkts[i]);
      tick();
    end
    bus.push = 1'b0;
    total_cnt++; if (bus.misroute_cnt !== exp_mis) $display("FAIL rx_filter_mis: got %0d expected %0d", bus.misroute_cnt, exp_mis); else pass_cnt++;
    total_cnt++; if (bus.rx_count !== 4'(rx_exp_q.size())) $display("FAIL rx_filter_count: got %0d expected %0d", bus.rx_count, rx_exp_q.size()); else pass_cnt++;
    while (rx_exp_q.size() > 0) begin
      exp_v = rx_exp_q.pop_front();
      total_cnt++; if ({bus.rx_valid, bus.rd_data} !== {1'b1, exp_v}) $display("FAIL rx_filter_data: got %b/%h expected 1/%h", bus.rx_valid, bus.rd_data, exp_v); else pass_cnt++;
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
    end
    total_cnt++; if ({bus.rx_valid, bus.rd_data, bus.err} !== '0) $display("FAIL rx_filter_empty: got %b/%h/%b expected 0/0000/0", bus.rx_valid, bus.rd_data, bus.err); else pass_cnt++;
  endtask

  task automatic test_rx_overflow();
    do_reset();
    for (int i = 0; i < D; i++) begin
      bus.push = 1'b1;
      bus.D_push = {(i[0] ? 8'hFF : 8'h02), 8'($urandom_range(0, 255))};
      model_push(bus.D_push);
      tick();
    end
    total_cnt++; if (bus.rx_count !== 4'd8) $display("FAIL rx_ovf_fill: got %0d expected 8", bus.rx_count); else pass_cnt++;
    // Push and read in the same cycle at full: the model applies the push before the read.
    bus.D_push = 16'h02AA; bus.rd_en = 1'b1;
    model_push(16'h02AA);
    exp_v = rx_exp_q.pop_front();
    total_cnt++; if (bus.rd_data !== exp_v) $display("FAIL rx_ovf_head: got %h expected %h", bus.rd_data, exp_v); else pass_cnt++;
    tick();
    bus.push = 1'b0; bus.rd_en = 1'b0;
    total_cnt++; if (bus.ovf_cnt !== exp_ovf) $display("FAIL rx_ovf_cnt: got %0d expected %0d", bus.ovf_cnt, exp_ovf); else pass_cnt++;
    total_cnt++; if (bus.rx_count !== 4'd7) $display("FAIL rx_ovf_count: got %0d expected 7", bus.rx_count); else pass_cnt++;
    // Simultaneous accepted push and read while partially full.
    bus.push = 1'b1; bus.D_push = 16'h02BB; bus.rd_en = 1'b1;
    model_push(16'h02BB);
    exp_v = rx_exp_q.pop_front();
    total_cnt++; if (bus.rd_data !== exp_v) $display("FAIL rx_pushrd_head: got %h expected %h", bus.rd_data, exp_v); else pass_cnt++;
    tick();
    bus.push = 1'b0; bus.rd_en = 1'b0;
    total_cnt++; if (bus.rx_count !== 4'd7) $display("FAIL rx_pushrd_count: got %0d expected 7", bus.rx_count); else pass_cnt++;
    while (rx_exp_q.size() > 0) begin
      exp_v = rx_exp_q.pop_front();
      total_cnt++; if (bus.rd_data !== exp_v) $display("FAIL rx_ovf_drain: got %h expected %h", bus.rd_data, exp_v); else pass_cnt++;
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
    end
  endtask

  task automatic test_misroute_sat();
    err_before = bus.err;
    for (int i = 0; i < 300; i++) begin
      bus.push = 1'b1;
      bus.D_push = {8'($urandom_range(3, 254)), 8'($urandom_range(0, 255))};
      model_push(bus.D_push);
      tick();
    end
    bus.push = 1'b0;
    total_cnt++; if (bus.misroute_cnt !== exp_mis) $display("FAIL mis_sat_cnt: got %0d expected %0d", bus.misroute_cnt, exp_mis); else pass_cnt++;
    total_cnt++; if (bus.misroute_cnt !== 8'd255) $display("FAIL mis_sat_255: got %0d expected 255", bus.misroute_cnt); else pass_cnt++;
    total_cnt++; if (bus.err !== err_before) $display("FAIL mis_sat_err: got %b expected %b", bus.err, err_before); else pass_cnt++;
    total_cnt++; if (bus.rx_count !== 4'd0) $display("FAIL mis_sat_rx: got %0d expected 0", bus.rx_count); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = W'($urandom_range(0, 16'hFFFF));
      bus.push = (i < 3); bus.D_push = {8'h02, 8'(i)};
      tick();
    end
    idle_inputs();
    total_cnt++; if ({bus.tx_count, bus.rx_count} !== {4'd5, 4'd3}) $display("FAIL mid_reset_pre: got %0d/%0d expected 5/3", bus.tx_count, bus.rx_count); else pass_cnt++;
    bus.pop = 1'b1; tick(); bus.pop = 1'b0;  // empty RX? no: sets err via nothing; just a legal pop
    bus.rd_en = 1'b1; bus.push = 1'b0; tick(); bus.rd_en = 1'b0;
    bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0;
    total_cnt++; if (bus.err !== 1'b1) $display("FAIL mid_reset_err_set: got %b expected 1", bus.err); else pass_cnt++;
    reset = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 16'h5A5A; bus.push = 1'b1; bus.D_push = 16'h02C3;
    tick();
    reset = 1'b0; idle_inputs();
    tx_exp_q.delete(); rx_exp_q.delete();
    total_cnt++; if ({bus.tx_count, bus.rx_count} !== 8'd0) $display("FAIL mid_reset_counts: got %0d/%0d expected 0/0", bus.tx_count, bus.rx_count); else pass_cnt++;
    total_cnt++; if ({bus.pndng, bus.rx_valid, bus.err} !== 3'b000) $display("FAIL mid_reset_flags: got %b expected 000", {bus.pndng, bus.rx_valid, bus.err}); else pass_cnt++;
    total_cnt++; if ({bus.D_pop, bus.rd_data} !== '0) $display("FAIL mid_reset_heads: got %h/%h expected 0/0", bus.D_pop, bus.rd_data); else pass_cnt++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    pass_cnt = 0; total_cnt = 0;
    exp_mis = 8'd0; exp_ovf = 8'd0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_tx_basic();
    test_tx_full();
    test_back_to_back();
    test_rx_filter();
    test_rx_overflow();
    test_misroute_sat();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
